serial_adder: RTL and testbench

- Parametrised bit-serial adder that adds two WIDTH-bit operands plus a carry-in.
- Uses a single full-adder cell and a registered carry, one bit per clock, LSB first.
- Sequential successor to the combinational full adder in BASIC-GATES.
- Used where area matters more than latency; start/busy/done handshake to the controlling logic.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to hold WIDTH-1 without wrapping, with one bit of headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, start/busy/done handshake.
// Build with SERIAL_ADDER_SUB_EN to add a 'sub' port selecting a-b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] opa, opb, res, res_nxt, b_load;
    logic [CW-1:0]    cnt;
    logic             carry, c_load, s_bit, c_bit, last;

    full_adder_cell u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (s_bit),
        .cout (c_bit)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 lands at res[0].
    generate
        if (WIDTH == 1) begin : g_res1
            assign res_nxt = s_bit;
        end else begin : g_resn
            assign res_nxt = {s_bit, res[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and seed the carry with 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= c_bit;
                    res   <= res_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum   <= res_nxt;
                        cout  <= c_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    localparam int W = 8;

    logic         clk, rst_n, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_sum = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one operation; inject>=0 pulses a spurious start during that sample index.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec,
                          input int inject, input string nm);
        int nb, nd, dpos;
        logic hold_bad;
        nb = 0; nd = 0; dpos = -1; hold_bad = 1'b0;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy) nb++;
            if (done) begin nd++; dpos = k; end
            if (k < W && sum !== last_sum) hold_bad = 1'b1;
            if (k == inject) begin
                a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk({nm, " sum"}, 64'(sum), 64'(es));
        chk({nm, " cout"}, 64'(cout), 64'(ec));
        chk({nm, " busy_cycles"}, 64'(nb), 64'(W));
        chk({nm, " done_pulses"}, 64'(nd), 64'd1);
        chk({nm, " done_pos"}, 64'(dpos), 64'(W));
        chk({nm, " sum_hold"}, 64'(hold_bad), 64'd0);
        last_sum = es;
        ts = ts; // keeps the argument referenced in the add-only build
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        // Reset with garbage on the inputs.
        rst_n = 1'b0; start = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst sum", 64'(sum), 64'd0);
        chk("rst cout", 64'(cout), 64'd0);
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", 64'(busy), 64'd0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].es, vecs[i].ec, -1,
                   $sformatf("vec%0d", i));

        // Spurious start during RUN cycle 3 must be ignored.
        run_op(8'hA5, 8'h3C, 1'b0, 1'b0, 8'hE1, 1'b0, 2, "busy_start");

        // Reset at RUN cycle 4 abandons the operation.
        begin
            int nd;
            nd = 0;
            @(negedge clk);
            a = 8'hA5; b = 8'h3C; cin = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk("midrst busy", 64'(busy), 64'd0);
            chk("midrst sum", 64'(sum), 64'd0);
            chk("midrst cout", 64'(cout), 64'd0);
            if (done) nd++;
            repeat (10) begin
                @(posedge clk); #1;
                if (done) nd++;
            end
            chk("midrst no_done", 64'(nd), 64'd0);
            last_sum = '0;
        end
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, -1, "after_rst");

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, -1, "sub_nb");
        run_op(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, -1, "sub_borrow");
        run_op(8'hA5, 8'h3C, 1'b0, 1'b0, 8'hE1, 1'b0, -1, "sub0_add");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
